axis_head_insert: RTL

Prepends a per-packet header of 0..MAX_HEAD bytes to an AXI-stream packet at byte granularity. Payload bytes are realigned across beat boundaries, and the output's last-beat tkeep is recomputed. This block is the transmit-side counterpart of the head-cut path: a packet that passes through this block and then a head-cut of the same byte count comes back unchanged. Inputs are a header sideband channel and the payload stream; the output is one AXI-stream master.

---
 rtl/axis_head_insert_pkg.sv | 37 +++
 rtl/axis_head_insert_merge.sv | 57 +++++
 rtl/axis_head_insert.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/axis_head_insert_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | axis_head_insert_pkg: shared state type and byte-count helpers      |
// | Revision: 1.0                                                       |
// +-------------------------------------------------------------------+
package axis_head_insert_pkg;

    localparam int MAX_DX = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2,
        TAIL = 2'd3
    } state_t;

    function automatic int keep_to_cnt(input logic [MAX_DX-1:0] keep);
        int n;
        n = 0;
        for (int i = 0; i < MAX_DX; i++) begin
            if (keep[i]) n = n + 1;
        end
        return n;
    endfunction

    // MSB-aligned mask of cnt ones inside a dx-bit keep field
    function automatic logic [MAX_DX-1:0] cnt_to_keep(input int cnt, input int dx);
        logic [MAX_DX-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DX; i++) begin
            m[i] = (i < dx) && (i >= dx - cnt);
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_head_insert_merge.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | axis_head_insert_merge: combine R carried bytes with a new beat     |
// | Revision: 1.0                                                       |
// +-------------------------------------------------------------------+
module axis_head_insert_merge
    import axis_head_insert_pkg::*;
#(
    parameter int DSIZE     = 32,
    parameter int BYTE_BITS = 8,
    localparam int DX       = DSIZE / BYTE_BITS,
    localparam int CW       = $clog2(DX + 1)
) (
    input  logic [DSIZE-1:0] carry,
    input  logic [CW-1:0]    rem,
    input  logic [DSIZE-1:0] beat,
    input  logic [CW-1:0]    cnt,
    output logic [DSIZE-1:0] out_data,
    output logic [DX-1:0]    out_keep,
    output logic [DSIZE-1:0] next_carry,
    output logic [DX-1:0]    tail_keep,
    output logic             tail_needed
);

    localparam int SW = $clog2(DSIZE + 1);

    logic [DX-1:0]    rem_keep;
    logic [DX-1:0]    cnt_keep;
    logic [DSIZE-1:0] carry_m;
    logic [DSIZE-1:0] beat_m;
    logic [CW-1:0]    room;
    logic [CW-1:0]    sum;
    logic [SW-1:0]    sh_rem;
    logic [SW-1:0]    sh_room;

    assign rem_keep = DX'(cnt_to_keep(int'(rem), DX));
    assign cnt_keep = DX'(cnt_to_keep(int'(cnt), DX));

    // Bytes outside the valid ranges are zeroed so the OR-merge stays clean
    for (genvar b = 0; b < DX; b++) begin : g_byte
        assign carry_m[b*BYTE_BITS +: BYTE_BITS] = carry[b*BYTE_BITS +: BYTE_BITS] & {BYTE_BITS{rem_keep[b]}};
        assign beat_m[b*BYTE_BITS +: BYTE_BITS]  = beat[b*BYTE_BITS +: BYTE_BITS]  & {BYTE_BITS{cnt_keep[b]}};
    end

    assign room    = CW'(DX) - rem;
    assign sum     = rem + cnt;
    assign sh_rem  = SW'(rem) * SW'(BYTE_BITS);
    assign sh_room = SW'(room) * SW'(BYTE_BITS);

    assign out_data    = carry_m | (beat_m >> sh_rem);
    assign next_carry  = beat_m << sh_room;
    assign tail_needed = (cnt > room);
    assign out_keep    = tail_needed ? '1 : DX'(cnt_to_keep(int'(sum), DX));
    assign tail_keep   = tail_needed ? DX'(cnt_to_keep(int'(sum) - DX, DX)) : '0;

endmodule
`default_nettype wire

// File: rtl/axis_head_insert.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | axis_head_insert: prepend a 0..MAX_HEAD byte header to AXI-stream   |
// | Revision: 1.0                                                       |
// +-------------------------------------------------------------------+
module axis_head_insert
    import axis_head_insert_pkg::*;
#(
    parameter int DSIZE     = 32,
    parameter int BYTE_BITS = 8,
    parameter int MAX_HEAD  = 16,
    localparam int DX       = DSIZE / BYTE_BITS,
    localparam int LW       = $clog2(MAX_HEAD + 1)
) (
    input  logic                          clock,
    input  logic                          rst_n,
    input  logic [LW-1:0]                 head_len,
    input  logic [MAX_HEAD*BYTE_BITS-1:0] head_data,
    input  logic                          head_valid,
    output logic                          head_ready,
    input  logic [DSIZE-1:0]              s_tdata,
    input  logic [DX-1:0]                 s_tkeep,
    input  logic                          s_tvalid,
    input  logic                          s_tlast,
    output logic                          s_tready,
    output logic [DSIZE-1:0]              m_tdata,
    output logic [DX-1:0]                 m_tkeep,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    input  logic                          m_tready
);

    localparam int CW  = $clog2(DX + 1);
    localparam int HW  = MAX_HEAD * BYTE_BITS;
    localparam int HSW = HW + 2 * DSIZE;

    state_t           state, state_next;
    logic [HSW-1:0]   head_sh;
    logic [HSW-1:0]   head_in;
    logic [LW-1:0]    hcnt;
    logic [CW-1:0]    rem;
    logic [DSIZE-1:0] carry;
    logic [DX-1:0]    tail_keep;
    logic [LW-1:0]    len_c, q_in;
    logic [CW-1:0]    r_in;
    logic             load_ok;

    logic [DSIZE-1:0] mg_carry, mg_beat, mg_data, mg_next;
    logic [CW-1:0]    mg_rem, mg_cnt;
    logic [DX-1:0]    mg_keep, mg_tkeep;
    logic             mg_tail;

    logic             ld, ld_last;
    logic [DSIZE-1:0] ld_data;
    logic [DX-1:0]    ld_keep;

    assign len_c   = (head_len > LW'(MAX_HEAD)) ? LW'(MAX_HEAD) : head_len;
    assign q_in    = len_c / LW'(DX);
    assign r_in    = CW'(len_c % LW'(DX));
    // Zero padding keeps the "next header beat" slice in range after the last shift
    assign head_in = {head_data, {(2*DSIZE){1'b0}}};
    assign load_ok = !m_tvalid || m_tready;

    // The merge either builds the header carry (no beat) or realigns a payload beat
    always_comb begin
        mg_carry = head_in[HSW-1 -: DSIZE];
        mg_rem   = r_in;
        mg_beat  = '0;
        mg_cnt   = '0;
        case (state)
            HEAD: begin
                mg_carry = head_sh[HSW-DSIZE-1 -: DSIZE];
                mg_rem   = rem;
            end
            BODY: begin
                mg_carry = carry;
                mg_rem   = rem;
                mg_beat  = s_tdata;
                mg_cnt   = CW'(keep_to_cnt(MAX_DX'(s_tkeep)));
            end
            default: ;
        endcase
    end

    axis_head_insert_merge #(
        .DSIZE     (DSIZE),
        .BYTE_BITS (BYTE_BITS)
    ) u_merge (
        .carry       (mg_carry),
        .rem         (mg_rem),
        .beat        (mg_beat),
        .cnt         (mg_cnt),
        .out_data    (mg_data),
        .out_keep    (mg_keep),
        .next_carry  (mg_next),
        .tail_keep   (mg_tkeep),
        .tail_needed (mg_tail)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (head_valid) state_next = (q_in != '0) ? HEAD : BODY;
            HEAD: if (load_ok && hcnt == LW'(1)) state_next = BODY;
            BODY: if (s_tvalid && load_ok && s_tlast) state_next = mg_tail ? TAIL : IDLE;
            TAIL: if (load_ok) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        head_ready = 1'b0;
        s_tready   = 1'b0;
        ld         = 1'b0;
        ld_data    = '0;
        ld_keep    = '0;
        ld_last    = 1'b0;
        case (state)
            IDLE: head_ready = 1'b1;
            HEAD: begin
                ld      = 1'b1;
                ld_data = head_sh[HSW-1 -: DSIZE];
                ld_keep = '1;
            end
            BODY: begin
                s_tready = load_ok;
                ld       = s_tvalid;
                ld_data  = mg_data;
                ld_keep  = mg_keep;
                ld_last  = s_tlast && !mg_tail;
            end
            TAIL: begin
                ld      = 1'b1;
                ld_data = carry;
                ld_keep = tail_keep;
                ld_last = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            head_sh   <= '0;
            hcnt      <= '0;
            rem       <= '0;
            carry     <= '0;
            tail_keep <= '0;
        end else begin
            case (state)
                IDLE: if (head_valid) begin
                    head_sh <= head_in;
                    hcnt    <= q_in;
                    rem     <= r_in;
                    carry   <= mg_data;
                end
                HEAD: if (load_ok) begin
                    head_sh <= head_sh << DSIZE;
                    hcnt    <= hcnt - LW'(1);
                    if (hcnt == LW'(1)) carry <= mg_data;
                end
                BODY: if (s_tvalid && load_ok) begin
                    carry     <= mg_next;
                    tail_keep <= mg_tkeep;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
        end else if (load_ok) begin
            m_tvalid <= ld;
            if (ld) begin
                m_tdata <= ld_data;
                m_tkeep <= ld_keep;
                m_tlast <= ld_last;
            end
        end
    end

endmodule
`default_nettype wire
